// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file: registered reads with write-to-read bypass,
// optional hard-wired-zero r0, and a scrub engine that zeroes every entry.
module reg_file_2r1w #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned DEPTH   = 16,
   parameter bit          ZERO_R0 = 1'b0,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_req,
   output logic              busy,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b
);

   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   typedef enum logic {IDLE, SCRUB} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_ok;
   logic              rd_ok_a, rd_ok_b;

   assign busy = (state_q == SCRUB);

   // A same-cycle clr_req in IDLE takes priority, so the write is dropped.
   assign wr_ok = we && !busy && !reset && !clr_req
                  && ({1'b0, wr_addr} < DEPTH_X)
                  && !(ZERO_R0 && (wr_addr == '0));

   assign rd_ok_a = ({1'b0, rd_addr_a} < DEPTH_X) && !(ZERO_R0 && (rd_addr_a == '0));
   assign rd_ok_b = ({1'b0, rd_addr_b} < DEPTH_X) && !(ZERO_R0 && (rd_addr_b == '0));

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = SCRUB;
               ptr_d   = '0;
            end
         end
         SCRUB: begin
            if (ptr_q == LAST) begin
               state_d = IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: begin
            state_d = SCRUB;
            ptr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SCRUB;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Storage deliberately has no reset so it can map onto distributed RAM.
   always_ff @(posedge clk) begin
      if (busy)
         mem[ptr_q] <= '0;
      else if (wr_ok)
         mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset || busy) begin
         rd_data_a <= '0;
         rd_data_b <= '0;
      end else begin
         if (!rd_ok_a)
            rd_data_a <= '0;
         else if (wr_ok && (wr_addr == rd_addr_a))
            rd_data_a <= wr_data;
         else
            rd_data_a <= mem[rd_addr_a];

         if (!rd_ok_b)
            rd_data_b <= '0;
         else if (wr_ok && (wr_addr == rd_addr_b))
            rd_data_b <= wr_data;
         else
            rd_data_b <= mem[rd_addr_b];
      end
   end

endmodule
